// File: rtl/team_06_i2s_pkg.sv
// rtl/team_06_i2s_pkg.sv - shared types and constants for the team_06 I2S receive path
package team_06_i2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/team_06_i2s_sclk_gen.sv
// rtl/team_06_i2s_sclk_gen.sv - bit clock divider with internal rise/fall tick strobes
module team_06_i2s_sclk_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic run,
    output logic sclk_out,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          wrap;

    // Ticks mark the cycle whose closing edge toggles sclk_out, so the
    // controller acts on the same edge the ADC sees.
    assign wrap      = run && (div_cnt == CNT_MAX);
    assign rise_tick = wrap && !sclk_out;
    assign fall_tick = wrap && sclk_out;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_cnt  <= '0;
            sclk_out <= 1'b0;
        end else if (!run) begin
            div_cnt  <= '0;
            sclk_out <= 1'b0;
        end else if (wrap) begin
            div_cnt  <= '0;
            sclk_out <= ~sclk_out;
        end else begin
            div_cnt  <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/team_06_i2s_rx_ctrl.sv
// rtl/team_06_i2s_rx_ctrl.sv - master-mode I2S receive controller with valid/ready sample output
module team_06_i2s_rx_ctrl
    import team_06_i2s_pkg::*;
#(
    parameter int DIV    = 4,
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              sd_in,
    output logic              sclk_out,
    output logic              ws_out,
    output logic [WORD_W-1:0] sample_out,
    output logic              sample_ch,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun
);

    localparam int BW = $clog2(WORD_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W);

    i2s_state_t        state;
    i2s_state_t        state_next;
    logic              run;
    logic              rise_tick;
    logic              fall_tick;
    logic              swap_pend;
    logic              word_done;
    logic              cur_ch;
    logic [BW-1:0]     bit_cnt;
    logic [WORD_W-2:0] shreg;
    logic [WORD_W-1:0] word_full;

    // Gating run with en lets the divider drop to idle on the same edge as the FSM.
    assign run       = en && (state != IDLE);
    assign word_full = {shreg, sd_in};
    assign word_done = rise_tick && (bit_cnt == LAST_BIT);
    assign cur_ch    = (state == RIGHT) ? CH_RIGHT : CH_LEFT;

    team_06_i2s_sclk_gen #(
        .DIV(DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .nrst     (nrst),
        .run      (run),
        .sclk_out (sclk_out),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en) state_next = LEFT;
            end
            LEFT: begin
                if (!en)                        state_next = IDLE;
                else if (fall_tick && swap_pend) state_next = RIGHT;
            end
            RIGHT: begin
                if (!en)                        state_next = IDLE;
                else if (fall_tick && swap_pend) state_next = LEFT;
            end
            default: state_next = IDLE;
        endcase
    end

    // Word select follows the next state, so it moves only on a slot swap or leaving/entering IDLE.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ws_out <= 1'b1;
        end else begin
            ws_out <= (state_next != LEFT);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            swap_pend <= 1'b0;
        end else if (!run) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            swap_pend <= 1'b0;
        end else begin
            if (rise_tick) begin
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt   <= '0;
                    swap_pend <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                    // bit_cnt == 0 is the one-bit delay slot; data starts after it.
                    if (bit_cnt != '0) shreg <= word_full[WORD_W-2:0];
                end
            end
            if (fall_tick) swap_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sample_out   <= '0;
            sample_ch    <= CH_LEFT;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (word_done && (!sample_valid || sample_ready)) begin
                sample_out   <= word_full;
                sample_ch    <= cur_ch;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            if (!en) begin
                overrun <= 1'b0;
            end else if (word_done && sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_team_06_i2s_rx_ctrl.sv
// tb/tb_team_06_i2s_rx_ctrl.sv - directed self-checking bench for team_06_i2s_rx_ctrl
module tb_team_06_i2s_rx_ctrl;

    localparam int DIV    = 4;
    localparam int WORD_W = 8;

    logic              clk;
    logic              nrst;
    logic              en;
    logic              sd_in;
    logic              sclk_out;
    logic              ws_out;
    logic [WORD_W-1:0] sample_out;
    logic              sample_ch;
    logic              sample_valid;
    logic              sample_ready;
    logic              overrun;

    int checks   = 0;
    int failures = 0;

    team_06_i2s_rx_ctrl #(
        .DIV   (DIV),
        .WORD_W(WORD_W)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .en          (en),
        .sd_in       (sd_in),
        .sclk_out    (sclk_out),
        .ws_out      (ws_out),
        .sample_out  (sample_out),
        .sample_ch   (sample_ch),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_sclk(input logic v);
        int n;
        n = 0;
        while (sclk_out !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sclk_out !== v) begin
            checks++;
            failures++;
            $display("FAIL wait_sclk sclk_out=%b required=%b after %0d clk", sclk_out, v, n);
        end
    endtask

    // ADC model: data changes after sclk falls; the delay-bit slot carries a 1 that must be ignored.
    task automatic send_slot(input logic [7:0] w, input int nbits, input bit ready_late);
        wait_sclk(1'b0);
        sd_in = 1'b1;
        wait_sclk(1'b1);
        for (int i = 7; i >= 8 - nbits; i--) begin
            wait_sclk(1'b0);
            sd_in = w[i];
            if (ready_late && i == 0) begin
                repeat (DIV - 1) @(negedge clk);
                sample_ready = 1'b1;
            end
            wait_sclk(1'b1);
        end
    endtask

    task automatic idle_gap(input logic rdy);
        en = 1'b0;
        sample_ready = rdy;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        en = 1'b0;
        sd_in = 1'b0;
        sample_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (sclk_out !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk_out); end
        checks++; if (ws_out !== 1'b1) begin failures++; $display("FAIL reset_ws got=%b exp=1", ws_out); end
        checks++; if (sample_out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", sample_out); end
        checks++; if (sample_ch !== 1'b0) begin failures++; $display("FAIL reset_ch got=%b exp=0", sample_ch); end
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_timing;
        int first_rise, first_fall, second_rise, ws_rise;
        logic ws_first;
        first_rise = 0; first_fall = 0; second_rise = 0; ws_rise = 0; ws_first = 1'bx;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        sd_in = 1'b0;
        sample_ready = 1'b1;
        en = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1) ws_first = ws_out;
            if (first_rise == 0 && sclk_out === 1'b1) first_rise = k;
            else if (first_rise != 0 && first_fall == 0 && sclk_out === 1'b0) first_fall = k;
            else if (first_fall != 0 && second_rise == 0 && sclk_out === 1'b1) second_rise = k;
            if (ws_rise == 0 && ws_out === 1'b1) ws_rise = k;
        end
        checks++; if (ws_first !== 1'b0) begin failures++; $display("FAIL timing_ws_enter got=%b exp=0", ws_first); end
        checks++; if (first_rise != 5) begin failures++; $display("FAIL timing_first_rise got=%0d exp=5", first_rise); end
        checks++; if (first_fall != 9) begin failures++; $display("FAIL timing_first_fall got=%0d exp=9", first_fall); end
        checks++; if (second_rise != 13) begin failures++; $display("FAIL timing_period got=%0d exp=13", second_rise); end
        checks++; if (ws_rise != 73) begin failures++; $display("FAIL timing_ws_slot got=%0d exp=73", ws_rise); end
    endtask

    task automatic test_stereo;
        idle_gap(1'b1);
        en = 1'b1;
        send_slot(8'hA5, 8, 1'b0);
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL stereo_l_valid got=%b exp=1", sample_valid); end
        checks++; if (sample_out !== 8'hA5) begin failures++; $display("FAIL stereo_l_out got=%h exp=a5", sample_out); end
        checks++; if (sample_ch !== 1'b0) begin failures++; $display("FAIL stereo_l_ch got=%b exp=0", sample_ch); end
        @(negedge clk);
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL stereo_l_consumed got=%b exp=0", sample_valid); end
        send_slot(8'h3C, 8, 1'b0);
        checks++; if (sample_out !== 8'h3C) begin failures++; $display("FAIL stereo_r_out got=%h exp=3c", sample_out); end
        checks++; if (sample_ch !== 1'b1) begin failures++; $display("FAIL stereo_r_ch got=%b exp=1", sample_ch); end
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL stereo_r_valid got=%b exp=1", sample_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL stereo_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_overrun;
        idle_gap(1'b1);
        sample_ready = 1'b0;
        en = 1'b1;
        send_slot(8'h11, 8, 1'b0);
        checks++; if (sample_out !== 8'h11) begin failures++; $display("FAIL ovr_first_out got=%h exp=11", sample_out); end
        send_slot(8'h22, 8, 1'b0);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        checks++; if (sample_out !== 8'h11) begin failures++; $display("FAIL ovr_held_out got=%h exp=11", sample_out); end
        checks++; if (sample_ch !== 1'b0) begin failures++; $display("FAIL ovr_held_ch got=%b exp=0", sample_ch); end
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL ovr_held_valid got=%b exp=1", sample_valid); end
        sample_ready = 1'b1;
        @(negedge clk);
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain_valid got=%b exp=0", sample_valid); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_ready_on_complete;
        idle_gap(1'b0);
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL roc_ovr_cleared got=%b exp=0", overrun); end
        en = 1'b1;
        send_slot(8'h5A, 8, 1'b0);
        checks++; if (sample_out !== 8'h5A) begin failures++; $display("FAIL roc_first_out got=%h exp=5a", sample_out); end
        send_slot(8'hC3, 8, 1'b1);
        checks++; if (sample_out !== 8'hC3) begin failures++; $display("FAIL roc_new_out got=%h exp=c3", sample_out); end
        checks++; if (sample_ch !== 1'b1) begin failures++; $display("FAIL roc_new_ch got=%b exp=1", sample_ch); end
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL roc_new_valid got=%b exp=1", sample_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL roc_overrun got=%b exp=0", overrun); end
        @(negedge clk);
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL roc_consumed got=%b exp=0", sample_valid); end
    endtask

    task automatic test_en_drop;
        idle_gap(1'b0);
        en = 1'b1;
        send_slot(8'h96, 8, 1'b0);
        checks++; if (sample_out !== 8'h96) begin failures++; $display("FAIL endrop_left_out got=%h exp=96", sample_out); end
        send_slot(8'hE7, 4, 1'b0);
        en = 1'b0;
        @(negedge clk);
        checks++; if (sclk_out !== 1'b0) begin failures++; $display("FAIL endrop_sclk got=%b exp=0", sclk_out); end
        checks++; if (ws_out !== 1'b1) begin failures++; $display("FAIL endrop_ws got=%b exp=1", ws_out); end
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL endrop_pending got=%b exp=1", sample_valid); end
        checks++; if (sample_ch !== 1'b0) begin failures++; $display("FAIL endrop_ch got=%b exp=0", sample_ch); end
        repeat (40) @(negedge clk);
        checks++; if (sample_out !== 8'h96) begin failures++; $display("FAIL endrop_no_new got=%h exp=96", sample_out); end
        checks++; if (sclk_out !== 1'b0) begin failures++; $display("FAIL endrop_idle_sclk got=%b exp=0", sclk_out); end
        sample_ready = 1'b1;
        @(negedge clk);
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL endrop_consumed got=%b exp=0", sample_valid); end
    endtask

    task automatic test_reset_mid;
        idle_gap(1'b0);
        en = 1'b1;
        send_slot(8'h7E, 8, 1'b0);
        send_slot(8'hFF, 3, 1'b0);
        #2;
        nrst = 1'b0;
        #1;
        checks++; if (sclk_out !== 1'b0) begin failures++; $display("FAIL rmid_sclk got=%b exp=0", sclk_out); end
        checks++; if (ws_out !== 1'b1) begin failures++; $display("FAIL rmid_ws got=%b exp=1", ws_out); end
        checks++; if (sample_out !== 8'h00) begin failures++; $display("FAIL rmid_out got=%h exp=00", sample_out); end
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", sample_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rmid_overrun got=%b exp=0", overrun); end
        @(negedge clk);
        nrst = 1'b1;
        sample_ready = 1'b1;
        @(negedge clk);
        checks++; if (ws_out !== 1'b0) begin failures++; $display("FAIL rmid_restart_ws got=%b exp=0", ws_out); end
        send_slot(8'h81, 8, 1'b0);
        checks++; if (sample_out !== 8'h81) begin failures++; $display("FAIL rmid_restart_out got=%h exp=81", sample_out); end
        checks++; if (sample_ch !== 1'b0) begin failures++; $display("FAIL rmid_restart_ch got=%b exp=0", sample_ch); end
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL rmid_restart_valid got=%b exp=1", sample_valid); end
    endtask

    initial begin
        test_reset;
        test_timing;
        test_stereo;
        test_overrun;
        test_ready_on_complete;
        test_en_drop;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
